reg_file_wb: RTL
================

# reg_file_wb

Architectural register bank at the receiving end of the write-back stage of the 8-bit pipelined processor. It commits `ans_wb` results into an 8 x 8-bit register file and serves two registered read ports to decode. Write-to-read bypass removes same-cycle write/read hazards. A per-register pending-write scoreboard raises `stall` while a source operand still has an outstanding write-back.

## Interface
Parameters:
- DATA_W, 8, register and data width
- ADDR_W, 3, register address width (2^ADDR_W registers; register 0 hardwired to zero)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- wb_en  in  1  commit `ans_wb` to `wb_addr` this cycle
- wb_addr  in  ADDR_W  write-back destination register
- ans_wb  in  DATA_W  write-back result
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- issue_en  in  1  decode issues an instruction that will write `issue_addr`
- issue_addr  in  ADDR_W  destination of the issued instruction
- rs_data  out  DATA_W  registered read data A
- rt_data  out  DATA_W  registered read data B
- stall  out  1  combinational; source operand has an outstanding write
- sb_err  out  1  sticky scoreboard error flag

## Operation
- Register file:
  - `regs[0]` always reads 0.
  - A write with `wb_addr==0` is discarded.
  - Otherwise, `wb_en` writes `ans_wb` to `regs[wb_addr]` at posedge.
- Read ports:
  - At posedge, `rs_data` is loaded from the value of `regs[rs_addr]`. `rt_data` likewise from `regs[rt_addr]`.
  - Bypass: if `wb_en`, `wb_addr==rs_addr` and `rs_addr!=0`, `rs_data` loads `ans_wb` instead of the stale array value. The same rule applies to rt.
- Scoreboard: one 2-bit counter `pend[r]` per register r=1..7. `pend[0]` is constant 0.
  - `issue_en` with `issue_addr!=0` and no `wb_en` to the same register: increment. If `pend==3`, the counter holds and `sb_err` sets.
  - `wb_en` with `wb_addr!=0` and no issue to the same register: decrement. If `pend==0`, the counter holds and `sb_err` sets.
  - Issue and write-back to the same register in one cycle: counter unchanged, no error.
  - `issue_addr==0` and `wb_addr==0` never touch the scoreboard.
- `stall` = `busy(rs_addr)` OR `busy(rt_addr)`.
  - `busy(r)` is true when `pend[r]!=0`.
  - Exception: `busy(r)` is false when `pend[r]==1` and `wb_en && wb_addr==r` this cycle, because the bypass covers that last write.
  - `stall` does not depend on `issue_en`.
- `sb_err`: once set, stays set until reset.
- Reset:
  - All `regs` are 0, all `pend` are 0, `rs_data`=0, `rt_data`=0, `sb_err`=0.
  - `stall`=0 during and after reset until an issue occurs.
  - Reset has priority over `wb_en` and `issue_en` in the same cycle; both are dropped.

## Timing
- Write latency: a write at edge N is visible via the array at reads sampled at edge N+1. It is visible via the bypass at edge N.
- Read latency: 1 cycle from address to `rs_data`/`rt_data`.
- Scoreboard update: at posedge. `stall` reflects updated counts in the cycle after the edge.
- `stall` is combinational from `rs_addr`, `rt_addr`, `wb_en`, `wb_addr` and `pend`. There is no combinational path from `ans_wb`.
- Simultaneous read of register 0 with `wb_en`, `wb_addr==0`: read returns 0.
- Reset mid-operation: all outstanding pending counts are lost. A later `wb_en` to a register with `pend==0` after reset sets `sb_err`; that is a defined, not undefined, outcome.

## Test plan
- Reset then read: assert reset 1 cycle, then `rs_addr=3`, `rt_addr=5` -> `rs_data=0`, `rt_data=0`, `stall=0`, `sb_err=0`.
- Write/read plus bypass:
  - Write 8'hA5 to r2 at edge N, read r2 at N+1 -> `rs_data=8'hA5`.
  - `wb_en` r4=8'h3C with `rt_addr=4` in the same cycle -> `rt_data=8'h3C` after that edge.
- Register 0 immunity: `wb_en`, `wb_addr=0`, `ans_wb=8'hFF`, then read r0 -> 0, and no `pend` change.
- Stall lifecycle:
  - Issue r6, then hold `rs_addr=6` -> `stall=1`.
  - In the cycle `wb_en` r6=8'h11 arrives -> `stall=0` and `rs_data=8'h11` next edge.
  - Issue plus write-back to r6 in the same cycle -> `pend[6]` unchanged.
- Scoreboard overflow/underflow:
  - 4 issues to r1 -> `pend[1]=3`, `sb_err=1`.
  - After reset, `wb_en` r7 with `pend[7]=0` -> `sb_err=1`, and r7 is still written.
- Reset mid-operation: issue r3 twice, assert reset together with `wb_en` r3=8'h77 -> r3 reads 0, `pend[3]=0`, `stall=0`.

Source files
------------

// File: rtl/reg_file_wb.sv
// Write-back register bank: 2^ADDR_W x DATA_W registers, two registered read ports
// with write-to-read bypass, and a per-register pending-write scoreboard driving stall.
module reg_file_wb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic              sb_err
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] reg_q  [NREG];
    logic [1:0]        pend_q [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   err_vec;

    logic [DATA_W-1:0] rs_data_reg, rt_data_reg;
    logic              sb_err_reg;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_q[gi]   = '0;
                assign pend_q[gi]  = 2'd0;
                assign busy[gi]    = 1'b0;
                assign err_vec[gi] = 1'b0;
            end else begin : g_live
                logic [DATA_W-1:0] data_reg;
                logic [1:0]        pend_reg;
                logic              inc, dec;

                assign inc = issue_en && (issue_addr == ADDR_W'(gi));
                assign dec = wb_en && (wb_addr == ADDR_W'(gi));

                always_ff @(posedge clk) begin
                    if (reset) begin
                        data_reg <= '0;
                        pend_reg <= 2'd0;
                    end else begin
                        if (dec)
                            data_reg <= ans_wb;
                        if (inc && !dec && pend_reg != 2'd3)
                            pend_reg <= pend_reg + 2'd1;
                        else if (dec && !inc && pend_reg != 2'd0)
                            pend_reg <= pend_reg - 2'd1;
                    end
                end

                assign reg_q[gi]   = data_reg;
                assign pend_q[gi]  = pend_reg;
                assign err_vec[gi] = (inc && !dec && pend_reg == 2'd3) ||
                                     (dec && !inc && pend_reg == 2'd0);
                // The last outstanding write arriving this cycle is covered by the bypass.
                assign busy[gi]    = (pend_reg != 2'd0) && !(pend_reg == 2'd1 && dec);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            sb_err_reg  <= 1'b0;
        end else begin
            rs_data_reg <= (wb_en && wb_addr == rs_addr && rs_addr != '0) ? ans_wb : reg_q[rs_addr];
            rt_data_reg <= (wb_en && wb_addr == rt_addr && rt_addr != '0) ? ans_wb : reg_q[rt_addr];
            sb_err_reg  <= sb_err_reg | (|err_vec);
        end
    end

    assign rs_data = rs_data_reg;
    assign rt_data = rt_data_reg;
    assign sb_err  = sb_err_reg;
    // Held low while reset is asserted so stale counts never stall decode.
    assign stall   = !reset && (busy[rs_addr] || busy[rt_addr]);

endmodule
